// File: rtl/fp_mul_seq_if.sv
// fp_mul_seq_if: operand/result handshake bundle for the sequential FP multiplier.
//   A, B       : binary32 operands, sampled on the accept edge
//   in_valid   : operands valid            in_ready : unit idle, can accept
//   result     : packed binary32 product   out_valid: result valid
//   out_ready  : consumer takes result     busy     : operation in flight
// master = producer/consumer side (testbench, ALU), slave = multiplier.
interface fp_mul_seq_if;
    logic [31:0] A;
    logic [31:0] B;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] result;
    logic        out_valid;
    logic        out_ready;
    logic        busy;

    modport master (
        output A, B, in_valid, out_ready,
        input  in_ready, result, out_valid, busy
    );

    modport slave (
        input  A, B, in_valid, out_ready,
        output in_ready, result, out_valid, busy
    );
endinterface

// File: rtl/fp_mul_seq.sv
// fp_mul_seq: sequential binary32 multiplier, one shift-add partial product per clock.
// Number conventions match the combinational divider: hidden bit from a non-zero
// exponent, 8-bit wrapping exponent, truncation, no NaN/Inf handling.
// Ports:
//   clk  : clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : fp_mul_seq_if.slave (operands in, result out, busy)
// Flow: IDLE --accept--> MUL (24 cycles) --> NORM (1 cycle) --> DONE --take--> IDLE
module fp_mul_seq (
    input  logic         clk,
    input  logic         rst,
    fp_mul_seq_if.slave  bus
);

    typedef enum logic [1:0] {IDLE, MUL, NORM, DONE} state_t;

    state_t      state_q, state_d;
    logic        sign_q, sign_d;
    logic        z_q, z_d;
    logic [7:0]  ea_q, ea_d, eb_q, eb_d;
    logic [23:0] ma_q, ma_d, mb_q, mb_d;
    logic [47:0] p_q, p_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [31:0] result_q, result_d;

    logic [7:0]  exp_n;
    logic [22:0] mant_n;

    // State register
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (bus.in_valid)          state_d = MUL;
            MUL:     if (cnt_q == 5'd23)        state_d = NORM;
            NORM:                               state_d = DONE;
            DONE:    if (bus.out_ready)         state_d = IDLE;
            default:                            state_d = IDLE;
        endcase
    end

    // Outputs decoded from state
    always_comb begin
        bus.in_ready  = (state_q == IDLE);
        bus.out_valid = (state_q == DONE);
        bus.busy      = (state_q != IDLE);
        bus.result    = result_q;
    end

    // Normalization: -127 mod 256 is +129; P[47] set means the product is in [2,4)
    assign exp_n  = ea_q + eb_q + 8'd129 + {7'd0, p_q[47]};
    assign mant_n = p_q[47] ? p_q[46:24] : p_q[45:23];

    // Datapath next-state
    always_comb begin
        sign_d   = sign_q;
        z_d      = z_q;
        ea_d     = ea_q;
        eb_d     = eb_q;
        ma_d     = ma_q;
        mb_d     = mb_q;
        p_d      = p_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        unique case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    sign_d = bus.A[31] ^ bus.B[31];
                    ea_d   = bus.A[30:23];
                    eb_d   = bus.B[30:23];
                    ma_d   = {|bus.A[30:23], bus.A[22:0]};
                    mb_d   = {|bus.B[30:23], bus.B[22:0]};
                    z_d    = (bus.A[30:0] == 31'd0) | (bus.B[30:0] == 31'd0);
                    p_d    = 48'd0;
                    cnt_d  = 5'd0;
                end
            end
            MUL: begin
                // 24x24 product fits in 48 bits, so the add never overflows
                if (mb_q[cnt_q]) p_d = p_q + (48'(ma_q) << cnt_q);
                cnt_d = cnt_q + 5'd1;
            end
            NORM: begin
                result_d = z_q ? {sign_q, 31'd0} : {sign_q, exp_n, mant_n};
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sign_q   <= 1'b0;
            z_q      <= 1'b0;
            ea_q     <= 8'd0;
            eb_q     <= 8'd0;
            ma_q     <= 24'd0;
            mb_q     <= 24'd0;
            p_q      <= 48'd0;
            cnt_q    <= 5'd0;
            result_q <= 32'd0;
        end else begin
            sign_q   <= sign_d;
            z_q      <= z_d;
            ea_q     <= ea_d;
            eb_q     <= eb_d;
            ma_q     <= ma_d;
            mb_q     <= mb_d;
            p_q      <= p_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
        end
    end

endmodule

// File: tb/tb_fp_mul_seq.sv
// tb_fp_mul_seq: directed self-checking bench for fp_mul_seq.
module tb_fp_mul_seq;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;

    fp_mul_seq_if bus ();

    fp_mul_seq dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // advance one edge, then sample/drive 1 time unit later
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue one operation with out_ready high and check latency, pulse width, value.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp, input string tag);
        int k;
        bus.out_ready = 1'b1;
        bus.A = a;
        bus.B = b;
        bus.in_valid = 1'b1;
        step();                     // accept edge
        bus.in_valid = 1'b0;
        bus.A = 32'hDEADBEEF;       // must not matter after accept
        bus.B = 32'h12345678;
        check({tag, "_busy"}, {31'd0, bus.busy}, 32'd1);
        k = 0;
        while (!bus.out_valid && k < 100) begin
            step();
            k++;
        end
        check({tag, "_lat"}, k, 32'd25);
        check({tag, "_res"}, bus.result, exp);
        step();
        check({tag, "_ovdrop"}, {31'd0, bus.out_valid}, 32'd0);
        check({tag, "_rdy"}, {31'd0, bus.in_ready}, 32'd1);
        check({tag, "_hold"}, bus.result, exp);
    endtask

    initial begin
        int k;
        logic [31:0] held;
        logic        seen;

        bus.A = 32'd0;
        bus.B = 32'd0;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;

        // reset state
        step();
        step();
        rst = 1'b0;
        check("rst_result", bus.result, 32'h0);
        check("rst_ovalid", {31'd0, bus.out_valid}, 32'd0);
        check("rst_busy", {31'd0, bus.busy}, 32'd0);
        check("rst_irdy", {31'd0, bus.in_ready}, 32'd1);

        // main function
        run_op(32'h40000000, 32'h40400000, 32'h40C00000, "2x3");
        run_op(32'h3FC00000, 32'h3FC00000, 32'h40100000, "1p5sq");
        run_op(32'h3F800000, 32'h3F800000, 32'h3F800000, "1x1");
        run_op(32'hC0000000, 32'h3F000000, 32'hBF800000, "neg2xhalf");
        run_op(32'h00000000, 32'hC2F60000, 32'h80000000, "zeroA");
        run_op(32'h3F800000, 32'h80000000, 32'h80000000, "zeroB");

        // backpressure: out_ready low for 10 cycles, in_valid pulse ignored
        bus.out_ready = 1'b0;
        bus.A = 32'h40000000;
        bus.B = 32'h40400000;
        bus.in_valid = 1'b1;
        step();
        bus.in_valid = 1'b0;
        k = 0;
        while (!bus.out_valid && k < 100) begin
            step();
            k++;
        end
        check("bp_lat", k, 32'd25);
        held = bus.result;
        check("bp_res", held, 32'h40C00000);
        for (int i = 0; i < 10; i++) begin
            if (i == 3) begin
                bus.A = 32'h3FC00000;
                bus.B = 32'h3FC00000;
                bus.in_valid = 1'b1;
            end else begin
                bus.in_valid = 1'b0;
            end
            step();
            check("bp_stable_res", bus.result, held);
            check("bp_stable_ov", {31'd0, bus.out_valid}, 32'd1);
            check("bp_irdy_low", {31'd0, bus.in_ready}, 32'd0);
        end
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        step();
        check("bp_ovdrop", {31'd0, bus.out_valid}, 32'd0);
        check("bp_irdy", {31'd0, bus.in_ready}, 32'd1);
        step();
        check("bp_pulse_ignored", {31'd0, bus.busy}, 32'd0);
        check("bp_res_hold", bus.result, 32'h40C00000);

        // reset in MUL iteration 10
        bus.A = 32'h40000000;
        bus.B = 32'h40400000;
        bus.in_valid = 1'b1;
        step();                     // accept
        bus.in_valid = 1'b0;
        for (int i = 0; i < 9; i++) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("mrst_result", bus.result, 32'h0);
        check("mrst_ovalid", {31'd0, bus.out_valid}, 32'd0);
        check("mrst_busy", {31'd0, bus.busy}, 32'd0);
        check("mrst_irdy", {31'd0, bus.in_ready}, 32'd1);
        seen = 1'b0;
        for (int i = 0; i < 30; i++) begin
            step();
            if (bus.out_valid) seen = 1'b1;
        end
        check("mrst_no_ovalid", {31'd0, seen}, 32'd0);
        run_op(32'h3FC00000, 32'h3FC00000, 32'h40100000, "post_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // global watchdog so the run always ends
    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "timeout");
    end
endmodule
